lockstep_ctrl_unit: RTL
=======================

# lockstep_ctrl_unit

Parametrised lockstep controller on the cluster peripheral interconnect. Manages NB_PAIRS core pairs, each independently switched between split and lockstep mode through a barrier-synchronised handshake with a programmable timeout. Sticky per-pair error flags and a maskable interrupt are provided. Sits behind the cluster wrapper as an XBAR_PERIPH_BUS slave and drives the per-pair lockstep enables into the cores' comparison logic.

## Interface
- ID_WIDTH, 2, width of the bus transaction ID
- NB_PAIRS, 4, number of core pairs (1..16)
- TIMEOUT_WIDTH, 16, width of the TIMEOUT register and the per-pair counters
- TIMEOUT_RST, 1024, reset value of TIMEOUT

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- req_i  in  1  bus request
- addr_i  in  32  byte address; addr_i[4:2] selects the register
- wen_i  in  1  0 = write, 1 = read
- wdata_i  in  32  write data
- be_i  in  4  byte enables
- id_i  in  ID_WIDTH  transaction ID
- gnt_o  out  1  grant
- r_valid_o  out  1  response valid
- r_opc_o  out  1  0 = OK, 1 = error
- r_id_o  out  ID_WIDTH  response ID
- r_rdata_o  out  32  read data
- barrier_matched_i  in  NB_PAIRS  bit k high: both cores of pair k are at the barrier
- lockstep_mode_o  out  NB_PAIRS  bit k high: pair k in lockstep
- irq_o  out  1  error interrupt

## Operation
- Registers. Widths wider than NB_PAIRS or TIMEOUT_WIDTH read 0 in the upper bits. Writes honour be_i per byte.
  - 0x00 MODE_REQ RW: requested mode per pair.
  - 0x04 MODE_STATUS RO: equals lockstep_mode_o.
  - 0x08 TIMEOUT RW: timeout in cycles; 0 = wait forever.
  - 0x0C ERR_STATUS W1C: sticky per-pair timeout flags.
  - 0x10 IRQ_EN RW: per-pair interrupt mask.
- Access rules:
  - Access to 0x14..0x1C: r_opc_o=1, rdata=0, no side effect.
  - Write to MODE_STATUS: r_opc_o=1, ignored.
- Per-pair FSM, states SPLIT, SYNC_ENTER, LOCKED, SYNC_EXIT:
  - SPLIT, MODE_REQ[k]=1: go to SYNC_ENTER; clear counter.
  - LOCKED, MODE_REQ[k]=0: go to SYNC_EXIT; clear counter.
  - SYNC_ENTER, barrier_matched_i[k]=1: go to LOCKED; set lockstep_mode_o[k].
  - SYNC_EXIT, barrier_matched_i[k]=1: go to SPLIT; clear lockstep_mode_o[k].
  - SYNC_x, no barrier, counter == TIMEOUT-1 and TIMEOUT != 0: timeout. Return to the originating stable state, set ERR_STATUS[k], and hardware rewrites MODE_REQ[k] to the current mode so the request is not retried.
  - SYNC_x, otherwise: counter++. The counter saturates and never wraps.
  - SYNC_ENTER, MODE_REQ[k] cleared by software: abort to SPLIT, no error. Symmetric for SYNC_EXIT and LOCKED.
- barrier_matched_i is ignored in SPLIT and LOCKED.
- irq_o = registered OR of (ERR_STATUS & IRQ_EN).
- Reset values:
  - All state registers SPLIT; MODE_REQ, ERR_STATUS, IRQ_EN = 0; TIMEOUT = TIMEOUT_RST.
  - Outputs lockstep_mode_o, irq_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o all 0.
  - Reset mid-handshake returns the pair to SPLIT with no error.

## Timing
- gnt_o = req_i combinationally; every request is granted the same cycle.
- Response:
  - r_valid_o is high exactly one cycle after each granted request, for one cycle, for reads and writes.
  - r_id_o is the registered id_i; r_opc_o and r_rdata_o are valid with r_valid_o.
  - Back-to-back requests give back-to-back responses.
- A write takes effect at the granting edge E.
- The FSM reacts at edge E+1, so SYNC starts with the cycle after E+1.
- lockstep_mode_o changes at the edge closing the first SYNC cycle with barrier_matched_i[k]=1. Minimum write-to-mode latency is 2 edges.
- Timeout: with TIMEOUT=N, the error is set at the edge closing the N-th consecutive SYNC cycle without a barrier. irq_o rises one edge later.
- A read returns register state before the edge, so a read in the same cycle as an update returns the old value.
- Simultaneous events:
  - Barrier and timeout in the same cycle: barrier wins, no error.
  - Software write to MODE_REQ[k] and hardware timeout rewrite in the same cycle: hardware wins.
  - W1C clear and new error set on the same bit in the same cycle: set wins.
  - Pairs are fully independent; any mix of pairs may transition in the same cycle.

## Test plan
- Reset -> all outputs 0. Reads return MODE_REQ=0, TIMEOUT=1024, ERR_STATUS=0.
- Enter, exit with barrier:
  - Write MODE_REQ=0x1, then barrier_matched_i=0x1 three cycles later -> lockstep_mode_o=0x1 one edge after the barrier; MODE_STATUS reads 0x1.
  - Write MODE_REQ=0x0, then barrier -> lockstep_mode_o=0x0.
- Timeout:
  - Setup: TIMEOUT=8, IRQ_EN=0x4, MODE_REQ=0x4, no barrier.
  - After 8 SYNC cycles: ERR_STATUS=0x4 and MODE_REQ reads 0x0; irq_o=1 one cycle later.
  - W1C 0x4 -> irq_o=0.
- Boundary races:
  - Barrier in the 8th SYNC cycle (TIMEOUT=8) -> LOCKED, ERR_STATUS=0.
  - TIMEOUT=0 with no barrier for 5000 cycles -> stays SYNC_ENTER, no error.
- Abort and reset:
  - MODE_REQ=0x2, then write 0x0 before any barrier -> pair 1 back in SPLIT, no error.
  - rst_ni low during SYNC_ENTER -> SPLIT, all registers at reset values.
- Bus:
  - Back-to-back read 0x04 (id=1), write 0x04 (id=2), read 0x18 (id=3) -> three consecutive r_valid_o cycles.
  - r_opc_o per response 0, 1, 1; r_id_o per response 1, 2, 3.
  - Partial write to TIMEOUT with be_i=0x1, wdata=0xAB -> TIMEOUT=0x04AB.

Source files
------------

// File: rtl/lockstep_ctrl_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lockstep_ctrl_unit : bus-programmed split/lockstep handshake for core pairs
// Rev 1.0
// ----------------------------------------------------------------------------
module lockstep_ctrl_unit #(
  parameter int ID_WIDTH      = 2,
  parameter int NB_PAIRS      = 4,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int TIMEOUT_RST   = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic [31:0]         addr_i,
  input  logic                wen_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          be_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                gnt_o,
  output logic                r_valid_o,
  output logic                r_opc_o,
  output logic [ID_WIDTH-1:0] r_id_o,
  output logic [31:0]         r_rdata_o,
  input  logic [NB_PAIRS-1:0] barrier_matched_i,
  output logic [NB_PAIRS-1:0] lockstep_mode_o,
  output logic                irq_o
);

  typedef enum logic [1:0] {
    SPLIT      = 2'd0,
    SYNC_ENTER = 2'd1,
    LOCKED     = 2'd2,
    SYNC_EXIT  = 2'd3
  } state_t;

  localparam logic [2:0] c_sel_mode_req = 3'd0;
  localparam logic [2:0] c_sel_status   = 3'd1;
  localparam logic [2:0] c_sel_timeout  = 3'd2;
  localparam logic [2:0] c_sel_err      = 3'd3;
  localparam logic [2:0] c_sel_irq_en   = 3'd4;

  logic [NB_PAIRS-1:0]      r_mode_req;
  logic [NB_PAIRS-1:0]      r_err_status;
  logic [NB_PAIRS-1:0]      r_irq_en;
  logic [NB_PAIRS-1:0]      r_lock;
  logic [TIMEOUT_WIDTH-1:0] r_timeout;
  state_t                   r_state [NB_PAIRS];
  logic [TIMEOUT_WIDTH-1:0] r_cnt   [NB_PAIRS];
  logic                     r_irq;
  logic                     r_valid;
  logic                     r_opc;
  logic [ID_WIDTH-1:0]      r_id;
  logic [31:0]              r_rdata;

  logic [2:0]               w_sel;
  logic                     w_wr;
  logic                     w_rd;
  logic                     w_bad;
  logic [31:0]              w_wmask;
  logic [31:0]              w_rd_val;
  logic [NB_PAIRS-1:0]      w_mode_req_wr;
  logic [NB_PAIRS-1:0]      w_irq_en_wr;
  logic [TIMEOUT_WIDTH-1:0] w_timeout_wr;
  logic [TIMEOUT_WIDTH-1:0] w_tmo_last;
  logic [NB_PAIRS-1:0]      w_err_clr;
  logic [NB_PAIRS-1:0]      w_timeout_hit;
  logic                     w_unused;

  assign w_sel    = addr_i[4:2];
  assign w_wr     = req_i & ~wen_i;
  assign w_rd     = req_i & wen_i;
  assign w_bad    = (w_sel > c_sel_irq_en) | (w_wr & (w_sel == c_sel_status));
  assign w_wmask  = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign w_unused = ^{addr_i[31:5], addr_i[1:0]};

  assign w_mode_req_wr = NB_PAIRS'((32'(r_mode_req) & ~w_wmask) | (wdata_i & w_wmask));
  assign w_irq_en_wr   = NB_PAIRS'((32'(r_irq_en) & ~w_wmask) | (wdata_i & w_wmask));
  assign w_timeout_wr  = TIMEOUT_WIDTH'((32'(r_timeout) & ~w_wmask) | (wdata_i & w_wmask));
  assign w_err_clr     = (w_wr && w_sel == c_sel_err) ? NB_PAIRS'(wdata_i & w_wmask) : '0;
  assign w_tmo_last    = r_timeout - TIMEOUT_WIDTH'(1);

  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      c_sel_mode_req: w_rd_val = 32'(r_mode_req);
      c_sel_status:   w_rd_val = 32'(r_lock);
      c_sel_timeout:  w_rd_val = 32'(r_timeout);
      c_sel_err:      w_rd_val = 32'(r_err_status);
      c_sel_irq_en:   w_rd_val = 32'(r_irq_en);
      default:        w_rd_val = '0;
    endcase
  end

  // A timeout only counts while the request is still pending and no barrier arrived.
  always_comb begin
    w_timeout_hit = '0;
    for (int k = 0; k < NB_PAIRS; k++) begin
      if (((r_state[k] == SYNC_ENTER && r_mode_req[k]) ||
           (r_state[k] == SYNC_EXIT && !r_mode_req[k])) &&
          !barrier_matched_i[k] && (r_timeout != '0) && (r_cnt[k] == w_tmo_last)) begin
        w_timeout_hit[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_opc   <= 1'b0;
      r_id    <= '0;
      r_rdata <= '0;
    end else begin
      r_valid <= req_i;
      r_id    <= id_i;
      if (req_i) begin
        r_opc   <= w_bad;
        r_rdata <= (w_rd && !w_bad) ? w_rd_val : 32'd0;
      end else begin
        r_opc   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  // Per-pair bit updates of r_mode_req come after the bus write so a timeout rewrite wins.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mode_req   <= '0;
      r_timeout    <= TIMEOUT_WIDTH'(TIMEOUT_RST);
      r_irq_en     <= '0;
      r_err_status <= '0;
      r_lock       <= '0;
      r_irq        <= 1'b0;
      for (int k = 0; k < NB_PAIRS; k++) begin
        r_state[k] <= SPLIT;
        r_cnt[k]   <= '0;
      end
    end else begin
      if (w_wr && w_sel == c_sel_mode_req) r_mode_req <= w_mode_req_wr;
      if (w_wr && w_sel == c_sel_timeout)  r_timeout  <= w_timeout_wr;
      if (w_wr && w_sel == c_sel_irq_en)   r_irq_en   <= w_irq_en_wr;
      r_err_status <= (r_err_status & ~w_err_clr) | w_timeout_hit;
      r_irq        <= |(r_err_status & r_irq_en);
      for (int k = 0; k < NB_PAIRS; k++) begin
        case (r_state[k])
          SPLIT: begin
            if (r_mode_req[k]) begin
              r_state[k] <= SYNC_ENTER;
              r_cnt[k]   <= '0;
            end
          end
          LOCKED: begin
            if (!r_mode_req[k]) begin
              r_state[k] <= SYNC_EXIT;
              r_cnt[k]   <= '0;
            end
          end
          SYNC_ENTER: begin
            if (!r_mode_req[k]) begin
              r_state[k] <= SPLIT;
            end else if (barrier_matched_i[k]) begin
              r_state[k] <= LOCKED;
              r_lock[k]  <= 1'b1;
            end else if (w_timeout_hit[k]) begin
              r_state[k]    <= SPLIT;
              r_mode_req[k] <= 1'b0;
            end else if (r_cnt[k] != '1) begin
              r_cnt[k] <= r_cnt[k] + TIMEOUT_WIDTH'(1);
            end
          end
          SYNC_EXIT: begin
            if (r_mode_req[k]) begin
              r_state[k] <= LOCKED;
            end else if (barrier_matched_i[k]) begin
              r_state[k] <= SPLIT;
              r_lock[k]  <= 1'b0;
            end else if (w_timeout_hit[k]) begin
              r_state[k]    <= LOCKED;
              r_mode_req[k] <= 1'b1;
            end else if (r_cnt[k] != '1) begin
              r_cnt[k] <= r_cnt[k] + TIMEOUT_WIDTH'(1);
            end
          end
          default: r_state[k] <= SPLIT;
        endcase
      end
    end
  end

  assign gnt_o           = req_i;
  assign r_valid_o       = r_valid;
  assign r_opc_o         = r_opc;
  assign r_id_o          = r_id;
  assign r_rdata_o       = r_rdata;
  assign lockstep_mode_o = r_lock;
  assign irq_o           = r_irq;

endmodule
`default_nettype wire
